// File: rtl/tilegen_pkg.sv
// Shared types and constants for the tile-generator CPU-bus loader.
// Holds the FSM encoding, the FIFO geometry and the latch-select address bit.
package tilegen_pkg;

   localparam int FIFO_DEPTH    = 4;
   localparam int PTR_W         = 2;
   localparam int CNT_W         = 3;
   localparam int LATCH_SEL_BIT = 13;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE1 = 3'd2,
      ST_STROBE2 = 3'd3,
      ST_HOLD    = 3'd4
   } state_t;

   typedef struct packed {
      logic [13:0] addr;
      logic [7:0]  data;
   } req_t;

   function automatic logic is_latch(input req_t r);
      return r.addr[LATCH_SEL_BIT];
   endfunction

endpackage

// File: rtl/tilegen_loader_fifo.sv
// Four-entry request FIFO with a registered ready flag.
// Ready reflects occupancy at the previous edge, so a full FIFO refuses a push even while popping.
module tilegen_loader_fifo
   import tilegen_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_push,
   input  req_t i_data,
   input  logic i_pop,
   output req_t o_head,
   output logic o_ready,
   output logic o_empty
);

   req_t             r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic             r_ready;
   logic             w_push_acc;
   logic             w_pop_acc;

   assign w_push_acc = i_push && r_ready;
   assign w_pop_acc  = i_pop && (r_count != '0);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push_acc, w_pop_acc})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ready  <= 1'b0;
      end else begin
         if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= w_count_nxt;
         r_ready <= (w_count_nxt < CNT_W'(FIFO_DEPTH));
      end
   end

   // NOTE: storage is not reset; the occupancy count alone decides what is valid.
   always_ff @(posedge i_clk) begin
      if (w_push_acc) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_ready = r_ready;
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/tilegen_loader.sv
// Queues CPU writes and replays them as 4-clock CUS42/CUS43 bus cycles.
// Define TILEGEN_LOADER_VBLANK_GATE_EN to hold tile-RAM writes until VBLANK.
module tilegen_loader
   import tilegen_pkg::*;
(
   input  logic        CLK_6M,
   input  logic        RST_N,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic [13:0] REQ_ADDR,
   input  logic [7:0]  REQ_DATA,
   input  logic        VBLANK,
   output logic [12:0] CA,
   output logic [7:0]  CD_OUT,
   output logic        CD_OE,
   output logic        RCS_N,
   output logic        LATCH_N,
   output logic        WE_N,
   output logic        BUSY
);

   state_t r_state;
   state_t w_state_nxt;
   req_t   w_req;
   req_t   w_head;
   req_t   r_cur;
   logic   w_fifo_empty;
   logic   r_head_vld;
   logic   w_start;
   logic   w_pop;

   assign w_req = '{addr: REQ_ADDR, data: REQ_DATA};

   tilegen_loader_fifo u_fifo (
      .i_clk   (CLK_6M),
      .i_rst_n (RST_N),
      .i_push  (REQ_VALID),
      .i_data  (w_req),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_ready (REQ_READY),
      .o_empty (w_fifo_empty)
   );

`ifdef TILEGEN_LOADER_VBLANK_GATE_EN
   assign w_start = r_head_vld && (is_latch(w_head) || VBLANK);
`else
   logic w_unused_vblank;
   assign w_unused_vblank = VBLANK;
   assign w_start         = r_head_vld;
`endif

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK_6M or negedge RST_N) begin
      if (!RST_N) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Head visibility lags one clock, so a fresh push reaches the bus two edges after acceptance.
   always_ff @(posedge CLK_6M or negedge RST_N) begin
      if (!RST_N) begin
         r_head_vld <= 1'b0;
         r_cur      <= '0;
      end else begin
         r_head_vld <= !w_fifo_empty;
         if (w_pop) r_cur <= w_head;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_nxt = ST_SETUP;
               w_pop       = 1'b1;
            end
         end
         ST_SETUP:   w_state_nxt = ST_STROBE1;
         ST_STROBE1: w_state_nxt = ST_STROBE2;
         ST_STROBE2: w_state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (w_start) begin
               w_state_nxt = ST_SETUP;
               w_pop       = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      CA      = '0;
      CD_OUT  = '0;
      CD_OE   = 1'b0;
      RCS_N   = 1'b1;
      LATCH_N = 1'b1;
      WE_N    = 1'b1;
      if (r_state != ST_IDLE) begin
         CA     = r_cur.addr[LATCH_SEL_BIT-1:0];
         CD_OUT = r_cur.data;
         CD_OE  = 1'b1;
         if (is_latch(r_cur)) LATCH_N = 1'b0;
         else                 RCS_N   = 1'b0;
         WE_N = !((r_state == ST_STROBE1) || (r_state == ST_STROBE2));
      end
   end

   assign BUSY = !w_fifo_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_tilegen_loader.sv
// Directed self-checking bench for tilegen_loader with a strobe-level scoreboard.
// Gate-specific scenarios follow TILEGEN_LOADER_VBLANK_GATE_EN.
module tb_tilegen_loader;
   import tilegen_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [13:0] req_addr = '0;
   logic [7:0]  req_data = '0;
   logic        vblank = 1'b1;
   logic [12:0] ca;
   logic [7:0]  cd_out;
   logic        cd_oe;
   logic        rcs_n;
   logic        latch_n;
   logic        we_n;
   logic        busy;

   int   n_checks = 0;
   int   n_pass = 0;
   req_t exp_q[$];
   int   gaps[$];
   logic gap_armed = 1'b0;
   int   n_strobes = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   we_width = 0;
   logic prev_we = 1'b1;
   logic saw_not_ready = 1'b0;
   req_t mon_e;

   tilegen_loader dut (
      .CLK_6M    (clk),
      .RST_N     (rst_n),
      .REQ_VALID (req_valid),
      .REQ_READY (req_ready),
      .REQ_ADDR  (req_addr),
      .REQ_DATA  (req_data),
      .VBLANK    (vblank),
      .CA        (ca),
      .CD_OUT    (cd_out),
      .CD_OE     (cd_oe),
      .RCS_N     (rcs_n),
      .LATCH_N   (latch_n),
      .WE_N      (we_n),
      .BUSY      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Strobe monitor: every write strobe is matched against the next expected entry.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_we  = 1'b1;
         we_width = 0;
      end else begin
         if (!we_n && prev_we) begin
            if (gap_armed) gaps.push_back(cyc - start_cyc);
            gap_armed = 1'b1;
            start_cyc = cyc;
            n_strobes++;
            we_width = 1;
            if (exp_q.size() == 0) begin
               check("unexpected_strobe_ca", 32'(ca), 32'hFFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               check("strobe_ca", 32'(ca), 32'(mon_e.addr[12:0]));
               check("strobe_cd", 32'(cd_out), 32'(mon_e.data));
               check("strobe_sel", 32'({rcs_n, latch_n}), mon_e.addr[13] ? 32'h2 : 32'h1);
               check("strobe_oe", 32'(cd_oe), 32'h1);
            end
         end else if (!we_n) begin
            we_width++;
         end else if (!prev_we) begin
            check("we_width", 32'(we_width), 32'd2);
         end
         prev_we = we_n;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [13:0] a, input logic [7:0] d);
      int   tries;
      logic acc;
      tries     = 0;
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      do begin
         acc = req_ready;
         if (!acc) saw_not_ready = 1'b1;
         step();
         tries++;
      end while (!acc && tries < 200);
      check("push_accepted", 32'(acc), 32'h1);
      if (acc) exp_q.push_back('{addr: a, data: d});
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int k;
      k = 0;
      while (busy && k < bound) begin
         step();
         k++;
      end
      check("drain_done", 32'(busy), 32'h0);
   endtask

   task automatic reset_gaps();
      gaps.delete();
      gap_armed = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, expected summary first", $time);
      $fatal(1);
   end

   initial begin
      int base;
      int k;

      // Reset values
      #2;
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_we_n", 32'(we_n), 32'h1);
      check("rst_rcs_n", 32'(rcs_n), 32'h1);
      check("rst_latch_n", 32'(latch_n), 32'h1);
      check("rst_cd_oe", 32'(cd_oe), 32'h0);
      check("rst_ca", 32'(ca), 32'h0);
      check("rst_cd", 32'(cd_out), 32'h0);
      step();
      #2 rst_n = 1'b1;
      step();
      check("ready_after_release", 32'(req_ready), 32'h1);

      // Single tile write with latency and strobe shape
      push(14'h0123, 8'hA5);
      check("latency_e0", 32'(cd_oe), 32'h0);
      step();
      check("latency_e1", 32'(cd_oe), 32'h0);
      k = 0;
      while (!cd_oe && k < 20) begin
         step();
         k++;
      end
      check("setup_reached", 32'(cd_oe), 32'h1);
      check("setup_we_n", 32'(we_n), 32'h1);
      check("setup_ca", 32'(ca), 32'h0123);
      check("setup_cd", 32'(cd_out), 32'hA5);
      check("setup_rcs_n", 32'(rcs_n), 32'h0);
      check("setup_latch_n", 32'(latch_n), 32'h1);
      step();
      check("strobe1_we_n", 32'(we_n), 32'h0);
      step();
      check("strobe2_we_n", 32'(we_n), 32'h0);
      step();
      check("hold_we_n", 32'(we_n), 32'h1);
      check("hold_cd_oe", 32'(cd_oe), 32'h1);
      step();
      check("idle_cd_oe", 32'(cd_oe), 32'h0);
      check("idle_rcs_n", 32'(rcs_n), 32'h1);
      check("idle_ca", 32'(ca), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);

      // Latch write followed back-to-back by a tile write
      reset_gaps();
      push(14'h2002, 8'h10);
      push(14'h0000, 8'hFF);
      wait_idle(60);
      check("b2b_gap", gaps.size() > 0 ? 32'(gaps[0]) : 32'hFFFF_FFFF, 32'd4);
      check("b2b_all_written", 32'(exp_q.size()), 32'd0);

      // FIFO pointer wrap: ten writes in order
      base = n_strobes;
      for (int i = 0; i < 10; i++) push(14'h0100 + 14'(i), 8'(i));
      wait_idle(200);
      check("wrap_strobes", 32'(n_strobes - base), 32'd10);
      check("wrap_all_written", 32'(exp_q.size()), 32'd0);

`ifdef TILEGEN_LOADER_VBLANK_GATE_EN
      // Fill with VBLANK low: four accepted, then drain on VBLANK
      vblank = 1'b0;
      base = n_strobes;
      req_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_addr = 14'h0200 + 14'(i);
         req_data = 8'h30 + 8'(i);
         step();
      end
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 14'h0200 + 14'(i), data: 8'h30 + 8'(i)});
      repeat (3) step();
      check("full_ready", 32'(req_ready), 32'h0);
      check("full_busy", 32'(busy), 32'h1);
      check("full_no_bus", 32'(cd_oe), 32'h0);
      check("full_no_strobe", 32'(n_strobes - base), 32'd0);
      reset_gaps();
      vblank = 1'b1;
      wait_idle(100);
      check("full_drained", 32'(n_strobes - base), 32'd4);
      check("full_gap_count", 32'(gaps.size()), 32'd3);
      foreach (gaps[i]) check("full_cadence", 32'(gaps[i]), 32'd4);
      check("full_queue_empty", 32'(exp_q.size()), 32'd0);

      // VBLANK falls during STROBE1: cycle completes, next tile entry waits
      base = n_strobes;
      push(14'h0300, 8'h77);
      push(14'h0301, 8'h78);
      k = 0;
      while (we_n && k < 50) begin
         step();
         k++;
      end
      vblank = 1'b0;
      repeat (15) step();
      check("gate_one_done", 32'(n_strobes - base), 32'd1);
      check("gate_busy", 32'(busy), 32'h1);
      check("gate_idle_bus", 32'(cd_oe), 32'h0);
      vblank = 1'b1;
      wait_idle(60);
      check("gate_resumed", 32'(n_strobes - base), 32'd2);

      // Latch entries ignore the gate
      vblank = 1'b0;
      base = n_strobes;
      push(14'h2005, 8'h99);
      wait_idle(40);
      check("latch_ungated", 32'(n_strobes - base), 32'd1);
      vblank = 1'b1;
`else
      // VBLANK has no effect on starting a cycle
      vblank = 1'b0;
      base = n_strobes;
      push(14'h0042, 8'h5A);
      wait_idle(40);
      check("ungated_tile", 32'(n_strobes - base), 32'd1);
      vblank = 1'b1;

      // Back-pressure: pushes outrun the 4-clock drain
      base = n_strobes;
      saw_not_ready = 1'b0;
      reset_gaps();
      for (int i = 0; i < 6; i++) push(14'h0200 + 14'(i), 8'h30 + 8'(i));
      wait_idle(100);
      check("bp_ready_dropped", 32'(saw_not_ready), 32'h1);
      check("bp_drained", 32'(n_strobes - base), 32'd6);
      check("bp_gap_count", 32'(gaps.size()), 32'd5);
      foreach (gaps[i]) check("bp_cadence", 32'(gaps[i]), 32'd4);
      check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

      // Reset during STROBE2 with three entries queued
      base = n_strobes;
      for (int i = 0; i < 4; i++) push(14'h0400 + 14'(i), 8'h50 + 8'(i));
      k = 0;
      while (we_n && k < 50) begin
         step();
         k++;
      end
      step();
      check("pre_reset_strobe2", 32'(we_n), 32'h0);
      #1 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("abort_we_n", 32'(we_n), 32'h1);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_ready", 32'(req_ready), 32'h0);
      check("abort_cd_oe", 32'(cd_oe), 32'h0);
      check("abort_rcs_n", 32'(rcs_n), 32'h1);
      #10 rst_n = 1'b1;
      base = n_strobes;
      repeat (20) step();
      check("flushed_no_strobe", 32'(n_strobes - base), 32'd0);
      check("flushed_busy", 32'(busy), 32'h0);
      check("flushed_ready", 32'(req_ready), 32'h1);
      push(14'h0500, 8'hC3);
      wait_idle(40);
      check("post_reset_write", 32'(n_strobes - base), 32'd1);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
